// File: rtl/npu_host_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : npu_host_loader_if
// Description : Bundles the host word stream (s_*) and the NPU memory-mapped
//               port (npu_*) seen by the host loader.
//               master : the loader (consumes stream, drives NPU port)
//               slave  : the environment (stream source + NPU instance)
//   s_data    [31:0] stream word, byte0 in [7:0]   (slave -> master)
//   s_valid          stream word valid             (slave -> master)
//   s_ready          loader accepts word           (master -> slave)
//   npu_ena          NPU port enable               (master -> slave)
//   npu_wea          NPU write enable              (master -> slave)
//   npu_addra [15:0] {1'b0, sel[2:0], idx[11:0]}   (master -> slave)
//   npu_dina  [31:0] NPU write data                (master -> slave)
//   npu_douta [31:0] NPU read data                 (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface npu_host_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        npu_ena;
  logic        npu_wea;
  logic [15:0] npu_addra;
  logic [31:0] npu_dina;
  logic [31:0] npu_douta;

  modport master (
    input  s_data, s_valid, npu_douta,
    output s_ready, npu_ena, npu_wea, npu_addra, npu_dina
  );

  modport slave (
    output s_data, s_valid, npu_douta,
    input  s_ready, npu_ena, npu_wea, npu_addra, npu_dina
  );
endinterface
`default_nettype wire

// File: rtl/npu_host_loader.sv
`default_nettype none
// ============================================================================
// Module      : npu_host_loader
// Description : Host-side initiator for the NPU memory-mapped port. Drains a
//               32-bit word stream (image, optionally all weight regions),
//               writes it into the NPU, triggers inference, waits a fixed
//               time, reads back the fc2 logit and reports it sign-extended.
//   clk, rst         clock, synchronous active-high reset
//   start            1-cycle pulse, begins a run when idle
//   load_weights     sampled at start: 1 = all regions, 0 = image only
//   busy             high from cycle after accepted start until done
//   done             1-cycle pulse, result valid that cycle
//   result [31:0]    sign-extended logit, held until next done
//   bus (master)     stream handshake + NPU port
// Revision    : 1.0 - initial release
// ============================================================================
module npu_host_loader #(
  parameter int IMG_WORDS   = 60,
  parameter int WC1_WORDS   = 23,
  parameter int WC2_WORDS   = 23,
  parameter int FC1_WORDS   = 330,
  parameter int FC2_WORDS   = 3,
  parameter int RESULT_WAIT = 2048,
  parameter int READ_LAT    = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          start,
  input  wire logic          load_weights,
  output logic               busy,
  output logic               done,
  output logic [31:0]        result,
  npu_host_loader_if.master  bus
);

  localparam int CNT_MAX = (RESULT_WAIT > READ_LAT) ? RESULT_WAIT : READ_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(RESULT_WAIT);
  localparam logic [CNT_W-1:0] C_LAT_LAST  = CNT_W'(READ_LAT - 1);

  localparam logic [15:0] C_ADDR_RST  = 16'h5000;
  localparam logic [15:0] C_ADDR_TRIG = 16'h5001;
  localparam logic [15:0] C_ADDR_REQ  = 16'h5002;

  localparam logic [2:0] C_SEL_IMG = 3'd0;
  localparam logic [2:0] C_SEL_WC1 = 3'd1;
  localparam logic [2:0] C_SEL_WC2 = 3'd2;
  localparam logic [2:0] C_SEL_FC1 = 3'd3;
  localparam logic [2:0] C_SEL_FC2 = 3'd4;

  // Outputs are registered, so each state names the cycle in which its
  // NPU access is visible on the port: S_RST_OP shows the 5000 write,
  // S_TRIG shows the last data write, the first S_WAIT cycle shows the
  // 5001 trigger, S_REQ shows the 5002 read and S_DONE shows done.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RST_OP = 4'd1,
    S_LOAD   = 4'd2,
    S_TRIG   = 4'd3,
    S_WAIT   = 4'd4,
    S_REQ    = 4'd5,
    S_CAPT   = 4'd6,
    S_DONE   = 4'd7
  } state_t;

  state_t             state_q, state_d;
  logic               lw_q, lw_d;
  logic [2:0]         sel_q, sel_d;
  logic [11:0]        idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               s_ready_q, s_ready_d;
  logic               ena_q, ena_d;
  logic               wea_q, wea_d;
  logic [15:0]        addra_q, addra_d;
  logic [31:0]        dina_q, dina_d;
  logic [31:0]        result_q, result_d;

  logic [11:0]        idx_last;
  logic               final_region;
  logic               unused_douta_hi;

  // Only the low 24 bits of the logit word carry information.
  assign unused_douta_hi = ^bus.npu_douta[31:24];

  always_comb begin
    idx_last = 12'(IMG_WORDS - 1);
    case (sel_q)
      C_SEL_WC1: idx_last = 12'(WC1_WORDS - 1);
      C_SEL_WC2: idx_last = 12'(WC2_WORDS - 1);
      C_SEL_FC1: idx_last = 12'(FC1_WORDS - 1);
      C_SEL_FC2: idx_last = 12'(FC2_WORDS - 1);
      default:   idx_last = 12'(IMG_WORDS - 1);
    endcase
  end

  // Image-only runs end after the image region; full runs after fc2.
  assign final_region = (sel_q == C_SEL_FC2) || ((sel_q == C_SEL_IMG) && !lw_q);

  always_comb begin
    state_d   = state_q;
    lw_d      = lw_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    s_ready_d = s_ready_q;
    ena_d     = 1'b0;
    wea_d     = 1'b0;
    addra_d   = addra_q;
    dina_d    = dina_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RST_OP;
          lw_d    = load_weights;
          busy_d  = 1'b1;
          ena_d   = 1'b1;
          wea_d   = 1'b1;
          addra_d = C_ADDR_RST;
          dina_d  = 32'd0;
        end
      end

      S_RST_OP: begin
        state_d   = S_LOAD;
        sel_d     = C_SEL_IMG;
        idx_d     = 12'd0;
        s_ready_d = 1'b1;
      end

      S_LOAD: begin
        if (bus.s_valid && s_ready_q) begin
          ena_d   = 1'b1;
          wea_d   = 1'b1;
          addra_d = {1'b0, sel_q, idx_q};
          dina_d  = bus.s_data;
          if (idx_q == idx_last) begin
            idx_d = 12'd0;
            if (final_region) begin
              // Drop s_ready together with the final data write so no
              // extra word is accepted.
              s_ready_d = 1'b0;
              state_d   = S_TRIG;
            end else begin
              sel_d = sel_q + 3'd1;
            end
          end else begin
            idx_d = idx_q + 12'd1;
          end
        end
      end

      S_TRIG: begin
        ena_d   = 1'b1;
        wea_d   = 1'b1;
        addra_d = C_ADDR_TRIG;
        dina_d  = 32'd0;
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // cnt_q is 0 in the cycle the trigger is on the port, so the read
        // appears after exactly RESULT_WAIT idle cycles.
        if (cnt_q == C_WAIT_LAST) begin
          ena_d   = 1'b1;
          wea_d   = 1'b0;
          addra_d = C_ADDR_REQ;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_REQ: begin
        cnt_d   = '0;
        state_d = S_CAPT;
      end

      S_CAPT: begin
        if (cnt_q == C_LAT_LAST) begin
          result_d = {{8{bus.npu_douta[23]}}, bus.npu_douta[23:0]};
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Done cycle: a start arriving here is ignored.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lw_q      <= 1'b0;
      sel_q     <= 3'd0;
      idx_q     <= 12'd0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_ready_q <= 1'b0;
      ena_q     <= 1'b0;
      wea_q     <= 1'b0;
      addra_q   <= 16'd0;
      dina_q    <= 32'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      lw_q      <= lw_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_ready_q <= s_ready_d;
      ena_q     <= ena_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      result_q  <= result_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign bus.s_ready   = s_ready_q;
  assign bus.npu_ena   = ena_q;
  assign bus.npu_wea   = wea_q;
  assign bus.npu_addra = addra_q;
  assign bus.npu_dina  = dina_q;

endmodule
`default_nettype wire

// File: tb/tb_npu_host_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_host_loader
// Description : Self-checking bench for npu_host_loader. A transaction-level
//               model predicts every NPU access, busy/s_ready/done/result
//               from the accepted stream words; a single compare process
//               checks the DUT against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_host_loader;

  localparam int RESULT_WAIT = 2048;
  localparam int READ_LAT    = 1;
  localparam int NEVER       = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_weights;
  logic        busy;
  logic        done;
  logic [31:0] result;

  npu_host_loader_if bus ();

  npu_host_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .load_weights (load_weights),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
  } op_t;

  op_t         exp_q[$];
  bit          checking   = 1'b0;
  bit          rst_prev   = 1'b0;
  bit          run_active = 1'b0;
  int          acc_cyc    = 0;
  int          done_cyc   = NEVER;
  int          words      = 0;
  int          total      = 0;
  int          run_writes = 0;
  logic [31:0] exp_result = 32'd0;
  logic [31:0] rdata      = 32'd0;
  bit          rd_pending = 1'b0;

  // stream driver controls
  int vmode    = 0;    // 0 always valid, 1 toggle, 2 random
  bit idx_data = 1'b1; // 1: word value = its stream index
  bit tog      = 1'b0;

  function automatic logic [15:0] addr_of(input int k);
    int sizes[5];
    int rem;
    sizes = '{60, 23, 23, 330, 3};
    rem   = k;
    for (int i = 0; i < 5; i++) begin
      if (rem < sizes[i]) return {1'b0, 3'(i), 12'(rem)};
      rem -= sizes[i];
    end
    return 16'hFFFF;
  endfunction

  function automatic logic [31:0] sext24(input logic [31:0] v);
    return {{8{v[23]}}, v[23:0]};
  endfunction

  // Compare + model advance, sampled mid-cycle.
  always @(negedge clk) begin
    bit  busy_exp;
    bit  srdy_exp;
    op_t op;
    cyc++;
    if (checking) begin
      if (run_active && cyc == done_cyc) exp_result = sext24(rdata);
      busy_exp = run_active && (cyc >= acc_cyc + 1) && (cyc < done_cyc);
      srdy_exp = run_active && (cyc >= acc_cyc + 2) && (words < total);
      if (rst_prev) begin
        chk("reset_addra", bus.npu_addra, 16'd0);
        chk("reset_dina", bus.npu_dina, 32'd0);
        chk("reset_result", result, 32'd0);
      end
      chk("busy", busy, busy_exp);
      chk("s_ready", bus.s_ready, srdy_exp);
      chk("done", done, run_active && (cyc == done_cyc));
      chk("result", result, exp_result);
      chk("wea_without_ena", bus.npu_wea & ~bus.npu_ena, 1'b0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        op = exp_q.pop_front();
        chk("ena", bus.npu_ena, 1'b1);
        chk("wea", bus.npu_wea, op.wr);
        chk("addra", bus.npu_addra, op.addr);
        if (op.wr) chk("dina", bus.npu_dina, op.data);
      end else begin
        chk("ena_idle", bus.npu_ena, 1'b0);
      end
    end

    if (bus.npu_ena && bus.npu_wea) run_writes++;
    if (bus.npu_ena && !bus.npu_wea && bus.npu_addra == 16'h5002) rd_pending = 1'b1;

    if (checking && !rst) begin
      if (start && !run_active) begin
        run_active = 1'b1;
        acc_cyc    = cyc;
        done_cyc   = NEVER;
        words      = 0;
        total      = load_weights ? 439 : 60;
        run_writes = 0;
        exp_q.push_back('{cyc + 1, 1'b1, 16'h5000, 32'd0});
      end else if (srdy_exp && bus.s_valid) begin
        exp_q.push_back('{cyc + 1, 1'b1, addr_of(words), bus.s_data});
        words++;
        if (words == total) begin
          exp_q.push_back('{cyc + 2, 1'b1, 16'h5001, 32'd0});
          exp_q.push_back('{cyc + 3 + RESULT_WAIT, 1'b0, 16'h5002, 32'd0});
          done_cyc = cyc + 3 + RESULT_WAIT + READ_LAT + 1;
        end
      end
      if (run_active && cyc == done_cyc) run_active = 1'b0;
    end

    if (rst) begin
      exp_q.delete();
      run_active = 1'b0;
      done_cyc   = NEVER;
      words      = 0;
      total      = 0;
      exp_result = 32'd0;
      checking   = 1'b1;
      rst_prev   = 1'b1;
    end else begin
      rst_prev = 1'b0;
    end
  end

  // NPU read-data model: valid only the cycle after the read, junk otherwise.
  always @(posedge clk) begin
    #1;
    if (rd_pending) begin
      bus.npu_douta = rdata;
      rd_pending    = 1'b0;
    end else begin
      bus.npu_douta = $urandom;
    end
  end

  // Stream source.
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    case (vmode)
      0:       bus.s_valid = 1'b1;
      1:       bus.s_valid = tog;
      default: bus.s_valid = 1'($urandom_range(0, 1));
    endcase
    bus.s_data = idx_data ? 32'(words) : $urandom;
  end

  // ---------------- stimulus ----------------
  task automatic wait_words(input int n);
    int k = 0;
    while (words < n && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("words_timeout", k < 5000, 1'b1);
  endtask

  task automatic do_run(input bit lw, input int vm, input bit idx, input logic [31:0] rd,
                        input int exp_writes, input logic [31:0] exp_res, input bit inject);
    int n = 0;
    vmode    = vm;
    idx_data = idx;
    rdata    = rd;
    @(posedge clk); #1;
    start        = 1'b1;
    load_weights = lw;
    @(posedge clk); #1;
    start        = 1'b0;
    load_weights = ~lw;
    if (inject) begin
      wait_words(200);
      start        = 1'b1;
      load_weights = 1'b0;
      @(posedge clk); #1;
      start        = 1'b0;
    end
    while (!done && n < 12000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", n < 12000, 1'b1);
    chk("result_literal", result, exp_res);
    if (inject) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("write_count", run_writes, exp_writes);
    chk("idle_after_run", busy, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    load_weights = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_s_ready", bus.s_ready, 1'b0);
    chk("reset_ena", bus.npu_ena, 1'b0);

    // T1 full load, index data
    do_run(1'b1, 0, 1'b1, 32'hAB812345, 441, 32'hFF812345, 1'b0);
    // T2 image only
    do_run(1'b0, 0, 1'b1, 32'h55012345, 62, 32'h00012345, 1'b0);
    // T3 toggling valid
    do_run(1'b1, 1, 1'b0, 32'hFF7FFFFF, 441, 32'h007FFFFF, 1'b0);
    // T4 logit sign extension
    do_run(1'b0, 2, 1'b0, 32'h00FFFF85, 62, 32'hFFFFFF85, 1'b0);
    do_run(1'b0, 0, 1'b0, 32'h0000007B, 62, 32'h0000007B, 1'b0);
    // T5 starts while busy and at done are ignored
    do_run(1'b1, 2, 1'b0, 32'h12800000, 441, 32'hFF800000, 1'b1);

    // T6 reset mid fc1 load, then a clean full run
    vmode    = 2;
    idx_data = 1'b0;
    rdata    = 32'h0;
    @(posedge clk); #1;
    start        = 1'b1;
    load_weights = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_words(150);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_s_ready", bus.s_ready, 1'b0);
    chk("abort_ena", bus.npu_ena, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_access", run_writes < 160, 1'b1);
    do_run(1'b1, 2, 1'b1, 32'h00000001, 441, 32'h00000001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
